// File: rtl/blit_engine.sv
// blit_engine: copies a full screen image or one sheet tile from ROM into the
// framebuffer write port, or fills the screen with a solid colour. One ROM read
// and one framebuffer write per cycle; destination/valid are delayed ROM_LATENCY
// cycles so they line up with rom_data.
// Optional feature macro: BLIT_TRANSPARENCY_EN (tile-mode pixels equal to
// TRANSPARENT_KEY are not written).
module blit_engine #(
    parameter int SCREEN_W    = 320,
    parameter int SCREEN_H    = 240,
    parameter int TILE_SIZE   = 16,
    parameter int SHEET_COLS  = 4,
    parameter int TILE_COUNT  = 16,
    parameter int COLOUR_W    = 3,
    parameter int ROM_LATENCY = 2,
    parameter logic [COLOUR_W-1:0] TRANSPARENT_KEY = '0,
    localparam int X_W = $clog2(SCREEN_W),
    localparam int Y_W = $clog2(SCREEN_H),
    localparam int A_W = $clog2(SCREEN_W * SCREEN_H),
    localparam int T_W = $clog2(TILE_COUNT)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [1:0]          src_sel,
    input  logic [T_W-1:0]      tile_idx,
    input  logic [X_W-1:0]      tile_x,
    input  logic [Y_W-1:0]      tile_y,
    input  logic [COLOUR_W-1:0] fill_colour,
    output logic [A_W-1:0]      rom_addr,
    output logic [1:0]          rom_sel,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic                wr_en,
    output logic [X_W-1:0]      wr_x,
    output logic [Y_W-1:0]      wr_y,
    output logic [COLOUR_W-1:0] wr_colour,
    output logic                busy,
    output logic                done
);

    localparam int SHEET_W = SHEET_COLS * TILE_SIZE;
    localparam int TILES_X = SCREEN_W / TILE_SIZE;
    localparam int TILES_Y = SCREEN_H / TILE_SIZE;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [1:0]            mode_q, src_sel_q;
    logic [COLOUR_W-1:0]   fill_q;
    logic [A_W-1:0]        tile_base_q;
    logic [X_W-1:0]        dx_base_q;
    logic [Y_W-1:0]        dy_base_q;
    logic [X_W-1:0]        px_q, px_d;
    logic [Y_W-1:0]        py_q, py_d;
    logic [ROM_LATENCY-1:0] vld_q;
    logic [X_W-1:0]        x_pipe_q [ROM_LATENCY];
    logic [Y_W-1:0]        y_pipe_q [ROM_LATENCY];

    logic        idx_bad, reject, issue, is_tile, is_fill, out_vld, keyed;
    logic [31:0] tile_base;
    logic [X_W-1:0] last_x;
    logic [Y_W-1:0] last_y;

    // With a power-of-two tile count every encodable index is legal.
    if (TILE_COUNT < (1 << T_W)) begin : g_idx_chk
        assign idx_bad = 32'(tile_idx) >= 32'(TILE_COUNT);
    end else begin : g_idx_full
        assign idx_bad = 1'b0;
    end

    // Request decode: rejection and sheet offset of the requested tile.
    always_comb begin
        tile_base = (32'(tile_idx) / 32'(SHEET_COLS)) * 32'(TILE_SIZE * SHEET_W)
                  + (32'(tile_idx) % 32'(SHEET_COLS)) * 32'(TILE_SIZE);
        reject    = (mode == 2'd1) && (idx_bad || (32'(tile_x) >= 32'(TILES_X)) ||
                                       (32'(tile_y) >= 32'(TILES_Y)));
    end

    assign is_tile = (mode_q == 2'd1);
    assign is_fill = mode_q[1];   // mode 3 behaves as fill
    assign last_x  = is_tile ? X_W'(TILE_SIZE - 1) : X_W'(SCREEN_W - 1);
    assign last_y  = is_tile ? Y_W'(TILE_SIZE - 1) : Y_W'(SCREEN_H - 1);

    // Latch the request so live input changes cannot disturb an operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q      <= '0;
            src_sel_q   <= '0;
            fill_q      <= '0;
            tile_base_q <= '0;
            dx_base_q   <= '0;
            dy_base_q   <= '0;
        end else if (state_q == StIdle && start) begin
            mode_q      <= mode;
            src_sel_q   <= src_sel;
            fill_q      <= fill_colour;
            tile_base_q <= A_W'(tile_base);
            dx_base_q   <= (mode == 2'd1) ? X_W'(32'(tile_x) * 32'(TILE_SIZE)) : '0;
            dy_base_q   <= (mode == 2'd1) ? Y_W'(32'(tile_y) * 32'(TILE_SIZE)) : '0;
        end
    end

    // State and pixel counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            px_q    <= '0;
            py_q    <= '0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
        end
    end

    // Next state; px doubles as the drain cycle counter.
    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = reject ? StDone : StRun;
                    px_d    = '0;
                    py_d    = '0;
                end
            end
            StRun: begin
                issue = 1'b1;
                if (px_q == last_x) begin
                    px_d = '0;
                    if (py_q == last_y) begin
                        py_d    = '0;
                        state_d = StDrain;
                    end else begin
                        py_d = py_q + 1'b1;
                    end
                end else begin
                    px_d = px_q + 1'b1;
                end
            end
            StDrain: begin
                if (px_q == X_W'(ROM_LATENCY - 1)) begin
                    px_d    = '0;
                    state_d = StDone;
                end else begin
                    px_d = px_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Destination/valid delay line matched to the ROM latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                x_pipe_q[i] <= '0;
                y_pipe_q[i] <= '0;
            end
        end else begin
            vld_q[0]    <= issue;
            x_pipe_q[0] <= dx_base_q + px_q;
            y_pipe_q[0] <= dy_base_q + py_q;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                vld_q[i]    <= vld_q[i-1];
                x_pipe_q[i] <= x_pipe_q[i-1];
                y_pipe_q[i] <= y_pipe_q[i-1];
            end
        end
    end

    // ROM address/select, only driven while pixels are being issued.
    always_comb begin
        rom_addr = '0;
        rom_sel  = '0;
        if (state_q == StRun) begin
            if (mode_q == 2'd0) begin
                rom_addr = A_W'(py_q) * A_W'(SCREEN_W) + A_W'(px_q);
                rom_sel  = src_sel_q;
            end else if (is_tile) begin
                rom_addr = tile_base_q + A_W'(py_q) * A_W'(SHEET_W) + A_W'(px_q);
                rom_sel  = 2'd3;
            end
        end
    end

`ifdef BLIT_TRANSPARENCY_EN
    assign keyed = is_tile && (rom_data == TRANSPARENT_KEY);
`else
    logic unused_key;
    assign unused_key = ^TRANSPARENT_KEY;
    assign keyed      = 1'b0;
`endif

    // Framebuffer write port and handshake outputs.
    always_comb begin
        out_vld   = vld_q[ROM_LATENCY-1];
        wr_en     = out_vld && !keyed;
        wr_x      = x_pipe_q[ROM_LATENCY-1];
        wr_y      = y_pipe_q[ROM_LATENCY-1];
        wr_colour = out_vld ? (is_fill ? fill_q : rom_data) : '0;
        busy      = (state_q == StRun) || (state_q == StDrain);
        done      = (state_q == StDone);
    end

endmodule
